// File: rtl/scan_frame_packer_if.sv
`default_nettype none
// ============================================================================
// Module      : scan_frame_packer_if
// Description : Framed 16-bit word stream from the scan frame packer to the
//               network sender. valid/ready handshake with start/end markers.
//   out_valid  master->slave  out_data/out_sop/out_eop are valid
//   out_data   master->slave  16-bit frame word
//   out_sop    master->slave  first word of a frame
//   out_eop    master->slave  last word of a frame (checksum)
//   out_ready  slave->master  sender accepts the current word
// Revision    : 1.0  initial release
// ============================================================================
interface scan_frame_packer_if;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_sop;
  logic        out_eop;
  logic        out_ready;

  modport master (
    output out_valid,
    output out_data,
    output out_sop,
    output out_eop,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_sop,
    input  out_eop,
    output out_ready
  );
endinterface
`default_nettype wire

// File: rtl/scan_frame_packer.sv
`default_nettype none
// ============================================================================
// Module      : scan_frame_packer
// Description : Collects one revolution of range points (delimited by the
//               zero_flag pulse) into a ping-pong buffer and streams each
//               committed revolution as a framed word sequence:
//                 SYNC, count, status, {pos, gray} x count, XOR checksum.
// Ports       :
//   clk            system clock
//   rst_n          asynchronous active-low reset
//   send_en        frame commit enable
//   zero_flag      one-cycle pulse, start of a revolution
//   target_valid   point strobe
//   target_pos     point distance
//   target_gray    point gray value
//   dust_cnt       dust counter, sampled at commit into the status word
//   out_if         framed output stream (master side)
//   frame_drop_cnt frames discarded because the read side was busy (saturating)
//   point_ovf      sticky: a point was dropped because the write bank was full
// Revision    : 1.0  initial release
// ============================================================================
module scan_frame_packer #(
  parameter int          MAX_POINTS = 1080,
  parameter int          ADDR_W     = 11,
  parameter logic [15:0] SYNC_WORD  = 16'hA55A
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        send_en,
  input  logic                        zero_flag,
  input  logic                        target_valid,
  input  logic [15:0]                 target_pos,
  input  logic [15:0]                 target_gray,
  input  logic [9:0]                  dust_cnt,
  scan_frame_packer_if.master         out_if,
  output logic [15:0]                 frame_drop_cnt,
  output logic                        point_ovf
);

  // Pointer/count width has one extra bit so it can hold MAX_POINTS itself.
  localparam int                PTR_W   = ADDR_W + 1;
  localparam logic [PTR_W-1:0]  MAX_PTR = PTR_W'(MAX_POINTS);
  localparam logic [PTR_W-1:0]  ONE     = PTR_W'(1);
  localparam logic [PTR_W-1:0]  TWO     = PTR_W'(2);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SYNC = 3'd1,
    ST_CNT  = 3'd2,
    ST_STAT = 3'd3,
    ST_POS  = 3'd4,
    ST_GRAY = 3'd5,
    ST_CSUM = 3'd6
  } state_t;

  // --------------------------------------------------------------------------
  // Write side state
  // --------------------------------------------------------------------------
  logic              wr_bank;      // bank owned by the write side; read side owns ~wr_bank
  logic [PTR_W-1:0]  wr_ptr;
  logic              ovf_frame;    // a point of the current revolution was dropped
  logic              start;        // one-cycle pulse: committed frame ready to stream
  logic [PTR_W-1:0]  frame_cnt;
  logic [15:0]       frame_stat;

  // --------------------------------------------------------------------------
  // Read side state
  // --------------------------------------------------------------------------
  state_t            state;
  logic [PTR_W-1:0]  pt_idx;       // index of the point currently on the output
  logic [ADDR_W-1:0] rd_addr;      // prefetch address (next point to be emitted)
  logic [15:0]       gray_hold;    // gray half of the point whose pos is on the output
  logic [15:0]       csum;         // XOR of all words accepted so far in this frame
  logic              frame_valid;
  logic [15:0]       frame_data;
  logic              frame_sop;
  logic              frame_eop;

  // --------------------------------------------------------------------------
  // Storage
  // --------------------------------------------------------------------------
  logic [31:0]       bank0 [MAX_POINTS];
  logic [31:0]       bank1 [MAX_POINTS];
  logic [31:0]       q0;
  logic [31:0]       q1;

  // --------------------------------------------------------------------------
  // Combinational control
  // --------------------------------------------------------------------------
  logic              busy;
  logic              commit;
  logic              wr_en;
  logic              wr_sel;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_word;
  logic [31:0]       mem_q;
  logic              accept;
  logic [PTR_W-1:0]  idx_p1;
  logic [PTR_W-1:0]  idx_p2;

  // The cycle between commit and entering SYNC counts as busy so that a
  // second zero_flag cannot steal the bank that is about to be streamed.
  assign busy    = (state != ST_IDLE) || start;
  assign commit  = zero_flag && send_en && !busy;

  // A point arriving together with zero_flag belongs to the next revolution:
  // it lands at address 0 of the bank that will be written after the swap.
  assign wr_en   = target_valid && (zero_flag || (wr_ptr < MAX_PTR));
  assign wr_sel  = commit ? ~wr_bank : wr_bank;
  assign wr_addr = zero_flag ? '0 : wr_ptr[ADDR_W-1:0];
  assign wr_word = {target_pos, target_gray};

  assign mem_q   = wr_bank ? q0 : q1;
  assign accept  = frame_valid && out_if.out_ready;
  assign idx_p1  = pt_idx + ONE;
  assign idx_p2  = pt_idx + TWO;

  assign out_if.out_valid = frame_valid;
  assign out_if.out_data  = frame_data;
  assign out_if.out_sop   = frame_sop;
  assign out_if.out_eop   = frame_eop;

  // --------------------------------------------------------------------------
  // Buffer: one write port (write bank) and a registered read (read bank).
  // The read bank is never written while it is owned by the read side, so
  // q tracks bank[rd_addr] with one cycle of lag.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (wr_en && !wr_sel) bank0[wr_addr] <= wr_word;
    if (wr_en &&  wr_sel) bank1[wr_addr] <= wr_word;
    q0 <= bank0[rd_addr];
    q1 <= bank1[rd_addr];
  end

  // --------------------------------------------------------------------------
  // Write side: point collection, commit / discard, drop accounting
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank        <= 1'b0;
      wr_ptr         <= '0;
      ovf_frame      <= 1'b0;
      start          <= 1'b0;
      frame_cnt      <= '0;
      frame_stat     <= '0;
      frame_drop_cnt <= '0;
      point_ovf      <= 1'b0;
    end else begin
      start <= commit;
      if (zero_flag) begin
        wr_ptr    <= target_valid ? ONE : '0;
        ovf_frame <= 1'b0;
        if (commit) begin
          wr_bank    <= ~wr_bank;
          frame_cnt  <= wr_ptr;
          frame_stat <= {ovf_frame, 5'b0, dust_cnt};
        end else if (send_en && (frame_drop_cnt != 16'hFFFF)) begin
          // send_en high without commit means the read side was busy
          frame_drop_cnt <= frame_drop_cnt + 16'd1;
        end
      end else if (target_valid) begin
        if (wr_ptr < MAX_PTR) begin
          wr_ptr <= wr_ptr + ONE;
        end else begin
          ovf_frame <= 1'b1;
          point_ovf <= 1'b1;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Read FSM with registered outputs. Each state's word is loaded into the
  // output register on acceptance of the previous word, so the stream runs
  // at one word per cycle. Point data is prefetched one point ahead.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      pt_idx      <= '0;
      rd_addr     <= '0;
      gray_hold   <= '0;
      csum        <= '0;
      frame_valid <= 1'b0;
      frame_data  <= '0;
      frame_sop   <= 1'b0;
      frame_eop   <= 1'b0;
    end else begin
      if (accept) csum <= csum ^ frame_data;

      case (state)
        ST_IDLE: begin
          csum <= '0;
          if (start) begin
            state       <= ST_SYNC;
            frame_valid <= 1'b1;
            frame_data  <= SYNC_WORD;
            frame_sop   <= 1'b1;
            frame_eop   <= 1'b0;
            pt_idx      <= '0;
            rd_addr     <= '0;
          end
        end

        ST_SYNC: begin
          if (accept) begin
            state      <= ST_CNT;
            frame_data <= 16'(frame_cnt);
            frame_sop  <= 1'b0;
          end
        end

        ST_CNT: begin
          if (accept) begin
            state      <= ST_STAT;
            frame_data <= frame_stat;
          end
        end

        ST_STAT: begin
          if (accept) begin
            if (frame_cnt != '0) begin
              // Point 0 has been sitting in q since shortly after SYNC.
              state      <= ST_POS;
              frame_data <= mem_q[31:16];
              gray_hold  <= mem_q[15:0];
              if (ONE < frame_cnt) rd_addr <= ONE[ADDR_W-1:0];
            end else begin
              state      <= ST_CSUM;
              frame_data <= csum ^ frame_data;
              frame_eop  <= 1'b1;
            end
          end
        end

        ST_POS: begin
          if (accept) begin
            state      <= ST_GRAY;
            frame_data <= gray_hold;
          end
        end

        ST_GRAY: begin
          if (accept) begin
            if (idx_p1 < frame_cnt) begin
              state      <= ST_POS;
              pt_idx     <= idx_p1;
              frame_data <= mem_q[31:16];
              gray_hold  <= mem_q[15:0];
              if (idx_p2 < frame_cnt) rd_addr <= idx_p2[ADDR_W-1:0];
            end else begin
              state      <= ST_CSUM;
              frame_data <= csum ^ frame_data;
              frame_eop  <= 1'b1;
            end
          end
        end

        ST_CSUM: begin
          if (accept) begin
            state       <= ST_IDLE;
            frame_valid <= 1'b0;
            frame_data  <= '0;
            frame_eop   <= 1'b0;
          end
        end

        default: begin
          state       <= ST_IDLE;
          frame_valid <= 1'b0;
          frame_sop   <= 1'b0;
          frame_eop   <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_scan_frame_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_scan_frame_packer
// Description : Self-checking bench for scan_frame_packer. A reference model
//               keeps the points of the current revolution in queues and
//               builds each expected frame word list from them; a monitor
//               collects accepted words and checks stall stability.
// Revision    : 1.0  initial release
// ============================================================================
module tb_scan_frame_packer;

  localparam int MAXP = 1080;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        send_en;
  logic        zero_flag;
  logic        target_valid;
  logic [15:0] target_pos;
  logic [15:0] target_gray;
  logic [9:0]  dust_cnt;
  logic [15:0] frame_drop_cnt;
  logic        point_ovf;

  scan_frame_packer_if bus ();

  scan_frame_packer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .send_en        (send_en),
    .zero_flag      (zero_flag),
    .target_valid   (target_valid),
    .target_pos     (target_pos),
    .target_gray    (target_gray),
    .dust_cnt       (dust_cnt),
    .out_if         (bus),
    .frame_drop_cnt (frame_drop_cnt),
    .point_ovf      (point_ovf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // reference model state
  logic [15:0] cur_pos[$];
  logic [15:0] cur_gray[$];
  bit          cur_ovf;
  bit          ovf_model;
  int          drop_model;
  logic [17:0] exp_q[$];   // {sop, eop, word}
  logic [17:0] got_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    checks++;
    assert (obs === req) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, req);
  endtask

  // --------------------------------------------------------------------------
  // Monitor: record accepted words, verify held outputs while stalled.
  // --------------------------------------------------------------------------
  bit          prev_stall = 1'b0;
  logic [17:0] prev_word;

  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_stall) begin
        chk("stall_valid_held", {31'd0, bus.out_valid}, 32'd1);
        chk("stall_word_held", {14'd0, bus.out_sop, bus.out_eop, bus.out_data}, {14'd0, prev_word});
      end
      if (bus.out_valid && bus.out_ready)
        got_q.push_back({bus.out_sop, bus.out_eop, bus.out_data});
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_word  = {bus.out_sop, bus.out_eop, bus.out_data};
    end else begin
      prev_stall = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Model helpers
  // --------------------------------------------------------------------------
  function automatic void model_add(input logic [15:0] p, input logic [15:0] g);
    if (cur_pos.size() < MAXP) begin
      cur_pos.push_back(p);
      cur_gray.push_back(g);
    end else begin
      cur_ovf   = 1'b1;
      ovf_model = 1'b1;
    end
  endfunction

  function automatic void model_frame(input logic [9:0] dust);
    logic [15:0] words[$];
    logic [15:0] x;
    words.push_back(16'hA55A);
    words.push_back(16'(cur_pos.size()));
    words.push_back({cur_ovf, 5'b0, dust});
    foreach (cur_pos[i]) begin
      words.push_back(cur_pos[i]);
      words.push_back(cur_gray[i]);
    end
    x = 16'h0000;
    foreach (words[i]) x = x ^ words[i];
    words.push_back(x);
    foreach (words[i])
      exp_q.push_back({(i == 0), (i == words.size() - 1), words[i]});
  endfunction

  // --------------------------------------------------------------------------
  // Stimulus tasks
  // --------------------------------------------------------------------------
  task automatic point(input logic [15:0] p, input logic [15:0] g);
    target_valid = 1'b1;
    target_pos   = p;
    target_gray  = g;
    model_add(p, g);
    @(posedge clk); #1;
    target_valid = 1'b0;
  endtask

  task automatic zero_pulse(input bit exp_commit, input bit with_pt,
                            input logic [15:0] p, input logic [15:0] g,
                            input logic [9:0] dust, input bit chk_lat);
    zero_flag = 1'b1;
    dust_cnt  = dust;
    if (with_pt) begin
      target_valid = 1'b1;
      target_pos   = p;
      target_gray  = g;
    end
    if (send_en && exp_commit) model_frame(dust);
    else if (send_en && drop_model < 65535) drop_model++;
    cur_pos.delete();
    cur_gray.delete();
    cur_ovf = 1'b0;
    if (with_pt) model_add(p, g);
    @(posedge clk); #1;
    zero_flag    = 1'b0;
    target_valid = 1'b0;
    dust_cnt     = 10'(($urandom));
    if (chk_lat) begin
      @(negedge clk);
      chk("latency_c1_valid", {31'd0, bus.out_valid}, 32'd0);
      @(negedge clk);
      chk("latency_c2_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("latency_c2_sop",   {31'd0, bus.out_sop},   32'd1);
      chk("latency_c2_data",  {16'd0, bus.out_data},  32'h0000A55A);
    end
  endtask

  task automatic wait_drain(input bit rnd, input int budget);
    int n = 0;
    int m;
    while (got_q.size() < exp_q.size() && n < budget) begin
      @(posedge clk); #1;
      if (rnd) bus.out_ready = 1'($urandom_range(0, 1));
      n++;
    end
    chk("drain_in_budget", {31'd0, (n < budget)}, 32'd1);
    bus.out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("frame_length", 32'(got_q.size()), 32'(exp_q.size()));
    m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < m; i++)
      chk($sformatf("frame_word%0d", i), {14'd0, got_q[i]}, {14'd0, exp_q[i]});
    got_q.delete();
    exp_q.delete();
  endtask

  // --------------------------------------------------------------------------
  // Directed sequence
  // --------------------------------------------------------------------------
  initial begin
    rst_n         = 1'b0;
    send_en       = 1'b1;
    zero_flag     = 1'b0;
    target_valid  = 1'b0;
    target_pos    = '0;
    target_gray   = '0;
    dust_cnt      = '0;
    bus.out_ready = 1'b1;
    cur_ovf       = 1'b0;
    ovf_model     = 1'b0;
    drop_model    = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_sop",   {31'd0, bus.out_sop},   32'd0);
    chk("rst_eop",   {31'd0, bus.out_eop},   32'd0);
    chk("rst_data",  {16'd0, bus.out_data},  32'd0);
    chk("rst_drop",  {16'd0, frame_drop_cnt}, 32'd0);
    chk("rst_ovf",   {31'd0, point_ovf},     32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // three fixed points, latency to SYNC checked
    point(16'd100, 16'd10);
    point(16'd200, 16'd20);
    point(16'd300, 16'd30);
    zero_pulse(1'b1, 1'b0, 16'd0, 16'd0, 10'd5, 1'b1);
    wait_drain(1'b0, 200);

    // empty revolution
    zero_pulse(1'b1, 1'b0, 16'd0, 16'd0, 10'd777, 1'b0);
    wait_drain(1'b0, 200);

    // point coincident with zero_flag opens the next revolution
    point(16'($urandom), 16'($urandom));
    point(16'($urandom), 16'($urandom));
    zero_pulse(1'b1, 1'b1, 16'hBEEF, 16'h1234, 10'($urandom), 1'b0);
    wait_drain(1'b0, 200);
    point(16'($urandom), 16'($urandom));
    zero_pulse(1'b1, 1'b0, 16'd0, 16'd0, 10'($urandom), 1'b0);
    wait_drain(1'b0, 200);

    // ten points streamed with random backpressure
    for (int i = 0; i < 10; i++) point(16'($urandom), 16'($urandom));
    zero_pulse(1'b1, 1'b0, 16'd0, 16'd0, 10'($urandom), 1'b0);
    wait_drain(1'b1, 400);

    // overflowing revolution, then point_ovf must remain sticky
    for (int i = 0; i < 1085; i++) point(16'($urandom), 16'($urandom));
    chk("ovf_set", {31'd0, point_ovf}, {31'd0, ovf_model});
    zero_pulse(1'b1, 1'b0, 16'd0, 16'd0, 10'($urandom), 1'b0);
    wait_drain(1'b0, 5000);
    for (int i = 0; i < 3; i++) point(16'($urandom), 16'($urandom));
    zero_pulse(1'b1, 1'b0, 16'd0, 16'd0, 10'($urandom), 1'b0);
    wait_drain(1'b0, 200);
    chk("ovf_sticky", {31'd0, point_ovf}, 32'd1);

    // read side stalled: first frame committed, next two dropped
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) point(16'($urandom), 16'($urandom));
    zero_pulse(1'b1, 1'b0, 16'd0, 16'd0, 10'($urandom), 1'b0);
    for (int i = 0; i < 2; i++) point(16'($urandom), 16'($urandom));
    zero_pulse(1'b0, 1'b0, 16'd0, 16'd0, 10'($urandom), 1'b0);
    point(16'($urandom), 16'($urandom));
    zero_pulse(1'b0, 1'b0, 16'd0, 16'd0, 10'($urandom), 1'b0);
    @(posedge clk); #1;
    chk("drop_cnt_two", {16'd0, frame_drop_cnt}, 32'(drop_model));
    bus.out_ready = 1'b1;
    wait_drain(1'b0, 300);

    // send_en low: frame discarded silently
    for (int i = 0; i < 5; i++) point(16'($urandom), 16'($urandom));
    send_en = 1'b0;
    zero_pulse(1'b0, 1'b0, 16'd0, 16'd0, 10'($urandom), 1'b0);
    repeat (20) @(posedge clk);
    #1;
    chk("send_off_no_output", 32'(got_q.size()), 32'd0);
    chk("send_off_drop_cnt", {16'd0, frame_drop_cnt}, 32'(drop_model));
    send_en = 1'b1;

    // reset in the middle of a frame
    for (int i = 0; i < 20; i++) point(16'($urandom), 16'($urandom));
    zero_pulse(1'b1, 1'b0, 16'd0, 16'd0, 10'($urandom), 1'b0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("pre_reset_streaming", {31'd0, bus.out_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("midrst_eop",   {31'd0, bus.out_eop},   32'd0);
    chk("midrst_data",  {16'd0, bus.out_data},  32'd0);
    chk("midrst_drop",  {16'd0, frame_drop_cnt}, 32'd0);
    chk("midrst_ovf",   {31'd0, point_ovf},     32'd0);
    got_q.delete();
    exp_q.delete();
    cur_pos.delete();
    cur_gray.delete();
    cur_ovf    = 1'b0;
    ovf_model  = 1'b0;
    drop_model = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) point(16'($urandom), 16'($urandom));
    zero_pulse(1'b1, 1'b0, 16'd0, 16'd0, 10'($urandom), 1'b1);
    wait_drain(1'b0, 200);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
